vec_dot_mac: RTL and testbench

Sequential, parametrised fixed-point dot-product engine; the next generation of the fixed-size vecvecN blocks. Vector length, element width, binary-point position, lane parallelism and overflow mode are all parameters. LANES element pairs are processed per cycle into a full-precision accumulator, then scaled and either saturated or wrapped. Sits in the navigation datapath wherever vector/matrix products are needed; it is the building block for the later matrix-vector unit.

---
 rtl/fxp_pkg.sv | 51 +++++
 rtl/fxp_mac_lanes.sv | 45 ++++
 rtl/vec_dot_mac.sv | 129 ++++++++++++
 tb/tb_vec_dot_mac.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers for the dot-product and matrix-vector engines.
// Provides the sequencer state encoding, the accumulator sizing rule and
// range-check / clamp helpers that work on a 64-bit signed carrier.
package fxp_pkg;

    // Widest intermediate carried through the range helpers.
    localparam int unsigned FXP_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } fxp_state_t;

    // Full-precision accumulator width: product width plus growth for n terms plus sign.
    function automatic int unsigned acc_width(input int unsigned n, input int unsigned w);
        return 2 * w + $clog2(n) + 1;
    endfunction

    // Largest value representable in a w-bit signed result.
    function automatic logic signed [FXP_MAX_W-1:0] fxp_max(input int unsigned w);
        logic signed [FXP_MAX_W-1:0] one;
        one = 64'sd1;
        return (one <<< (w - 1)) - one;
    endfunction

    // Smallest value representable in a w-bit signed result.
    function automatic logic signed [FXP_MAX_W-1:0] fxp_min(input int unsigned w);
        logic signed [FXP_MAX_W-1:0] one;
        one = 64'sd1;
        return -(one <<< (w - 1));
    endfunction

    function automatic logic fxp_out_of_range(input logic signed [FXP_MAX_W-1:0] s,
                                              input int unsigned w);
        return (s > fxp_max(w)) || (s < fxp_min(w));
    endfunction

    // Clamp s into the w-bit signed range; caller truncates to w bits.
    function automatic logic signed [FXP_MAX_W-1:0] fxp_clamp(input logic signed [FXP_MAX_W-1:0] s,
                                                              input int unsigned w);
        if (s > fxp_max(w)) begin
            return fxp_max(w);
        end else if (s < fxp_min(w)) begin
            return fxp_min(w);
        end
        return s;
    endfunction

endpackage

// File: rtl/fxp_mac_lanes.sv
// Combinational sum of LANES signed element products starting at element idx.
// Lanes whose element index reaches VECTOR_SIZE select nothing and add zero.
// Ports:
//   elem_a, elem_b : packed vectors, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   idx            : first element handled this cycle
//   sum_c          : signed sum of the active lane products, SUM_W bits
module fxp_mac_lanes #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned VECTOR_SIZE = 4,
    parameter int unsigned LANES       = 2,
    parameter int unsigned IDX_W       = 3,
    parameter int unsigned SUM_W       = 35
) (
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] elem_a,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] elem_b,
    input  logic [IDX_W-1:0]                  idx,
    output logic signed [SUM_W-1:0]           sum_c
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;

    // Per lane: element mux (no match leaves zero), one multiplier, accumulate.
    always_comb begin
        logic signed [DATA_WIDTH-1:0] a_sel;
        logic signed [DATA_WIDTH-1:0] b_sel;
        logic signed [PROD_W-1:0]     prod;
        sum_c = '0;
        a_sel = '0;
        b_sel = '0;
        prod  = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            a_sel = '0;
            b_sel = '0;
            for (int j = 0; j < int'(VECTOR_SIZE); j++) begin
                if (IDX_W'(j) == (idx + IDX_W'(l))) begin
                    a_sel = elem_a[j*DATA_WIDTH +: DATA_WIDTH];
                    b_sel = elem_b[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            prod  = PROD_W'(a_sel) * PROD_W'(b_sel);
            sum_c = sum_c + SUM_W'(prod);
        end
    end

endmodule

// File: rtl/vec_dot_mac.sv
// Sequential fixed-point dot product: LANES products per cycle into a
// full-precision accumulator, then scaled by BIN_POS and saturated or wrapped.
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   start           : request, taken only while ready is high
//   vec_a, vec_b    : operand vectors, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ready           : idle or done, a start will be accepted
//   complete        : dot and overflow hold a valid result
//   dot, overflow   : scaled result and out-of-range flag
module vec_dot_mac
    import fxp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned BIN_POS     = 8,
    parameter int unsigned VECTOR_SIZE = 4,
    parameter int unsigned LANES       = 2,
    parameter int unsigned SATURATE    = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vec_a,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vec_b,
    output logic                              ready,
    output logic                              complete,
    output logic [DATA_WIDTH-1:0]             dot,
    output logic                              overflow
);

    localparam int unsigned VEC_W = VECTOR_SIZE * DATA_WIDTH;
    localparam int unsigned ACC_W = acc_width(VECTOR_SIZE, DATA_WIDTH);
    // Index must hold values up to VECTOR_SIZE-1+LANES without wrapping.
    localparam int unsigned IDX_W = $clog2(VECTOR_SIZE + LANES + 1);

    fxp_state_t                  state_q;
    fxp_state_t                  state_nx;
    logic                        accept_c;
    logic [VEC_W-1:0]            a_q;
    logic [VEC_W-1:0]            b_q;
    logic [IDX_W-1:0]            idx_q;
    logic signed [ACC_W-1:0]     acc_q;
    logic signed [ACC_W-1:0]     lane_sum_c;
    logic signed [ACC_W-1:0]     shifted_c;
    logic signed [FXP_MAX_W-1:0] wide_c;
    logic                        ovf_c;
    logic [DATA_WIDTH-1:0]       dot_c;

    fxp_mac_lanes #(
        .DATA_WIDTH  (DATA_WIDTH),
        .VECTOR_SIZE (VECTOR_SIZE),
        .LANES       (LANES),
        .IDX_W       (IDX_W),
        .SUM_W       (ACC_W)
    ) u_lanes (
        .elem_a (a_q),
        .elem_b (b_q),
        .idx    (idx_q),
        .sum_c  (lane_sum_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next state and operand-accept strobe.
    always_comb begin
        state_nx = state_q;
        accept_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nx = ST_RUN;
                    accept_c = 1'b1;
                end
            end
            ST_RUN: begin
                if ((idx_q + IDX_W'(LANES)) >= IDX_W'(VECTOR_SIZE)) begin
                    state_nx = ST_FINAL;
                end
            end
            ST_FINAL: state_nx = ST_DONE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Scale by the binary point (floor), then range-check and saturate or wrap.
    always_comb begin
        shifted_c = acc_q >>> BIN_POS;
        wide_c    = FXP_MAX_W'(shifted_c);
        ovf_c     = fxp_out_of_range(wide_c, DATA_WIDTH);
        dot_c     = DATA_WIDTH'((SATURATE != 0) ? fxp_clamp(wide_c, DATA_WIDTH) : wide_c);
    end

    // Operand capture, accumulation and result/handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            dot      <= '0;
            overflow <= 1'b0;
            ready    <= 1'b1;
            complete <= 1'b0;
        end else begin
            if (accept_c) begin
                a_q   <= vec_a;
                b_q   <= vec_b;
                idx_q <= '0;
                acc_q <= '0;
            end else if (state_q == ST_RUN) begin
                idx_q <= idx_q + IDX_W'(LANES);
                acc_q <= acc_q + lane_sum_c;
            end
            if (state_q == ST_FINAL) begin
                dot      <= dot_c;
                overflow <= ovf_c;
            end
            ready    <= (state_nx == ST_IDLE) || (state_nx == ST_DONE);
            complete <= (state_nx == ST_DONE);
        end
    end

endmodule

// File: tb/tb_vec_dot_mac.sv
// Self-checking bench for vec_dot_mac: four parameterisations checked against
// a plain-arithmetic dot-product reference.
module tb_vec_dot_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4;
    logic        start5;
    logic [63:0] va4, vb4;
    logic [79:0] va5, vb5;

    logic        rdy_s, cmp_s, ovf_s;
    logic [15:0] dot_s;
    logic        rdy_w, cmp_w, ovf_w;
    logic [15:0] dot_w;
    logic        rdy_52, cmp_52, ovf_52;
    logic [15:0] dot_52;
    logic        rdy_55, cmp_55, ovf_55;
    logic [15:0] dot_55;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vec_dot_mac #(.DATA_WIDTH(16), .BIN_POS(8), .VECTOR_SIZE(4), .LANES(2), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .start(start4), .vec_a(va4), .vec_b(vb4),
        .ready(rdy_s), .complete(cmp_s), .dot(dot_s), .overflow(ovf_s));

    vec_dot_mac #(.DATA_WIDTH(16), .BIN_POS(8), .VECTOR_SIZE(4), .LANES(2), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .start(start4), .vec_a(va4), .vec_b(vb4),
        .ready(rdy_w), .complete(cmp_w), .dot(dot_w), .overflow(ovf_w));

    vec_dot_mac #(.DATA_WIDTH(16), .BIN_POS(8), .VECTOR_SIZE(5), .LANES(2), .SATURATE(1)) u_n5l2 (
        .clk(clk), .rst(rst), .start(start5), .vec_a(va5), .vec_b(vb5),
        .ready(rdy_52), .complete(cmp_52), .dot(dot_52), .overflow(ovf_52));

    vec_dot_mac #(.DATA_WIDTH(16), .BIN_POS(8), .VECTOR_SIZE(5), .LANES(5), .SATURATE(1)) u_n5l5 (
        .clk(clk), .rst(rst), .start(start5), .vec_a(va5), .vec_b(vb5),
        .ready(rdy_55), .complete(cmp_55), .dot(dot_55), .overflow(ovf_55));

    // Reference: exact integer dot product, floor-scaled, then clamp or wrap.
    function automatic void model(input logic [79:0] a, input logic [79:0] b, input int n,
                                  input bit sat, output logic [15:0] d, output logic o);
        longint acc;
        longint s;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            acc += longint'($signed(a[i*16 +: 16])) * longint'($signed(b[i*16 +: 16]));
        end
        s = acc >>> 8;
        o = (s > 32767) || (s < -32768);
        if (sat && s > 32767)       d = 16'h7FFF;
        else if (sat && s < -32768) d = 16'h8000;
        else                        d = s[15:0];
    endfunction

    function automatic logic [15:0] rand_elem();
        logic [15:0] r;
        if ($urandom_range(0, 3) == 0) r = 16'($urandom);
        else r = 16'($signed($urandom_range(0, 2048)) - 1024);
        return r;
    endfunction

    task automatic run4(input logic [63:0] a, input logic [63:0] b);
        logic [15:0] ds, dw;
        logic        os, ow;
        int          cyc;
        model({16'h0, a}, {16'h0, b}, 4, 1'b1, ds, os);
        model({16'h0, a}, {16'h0, b}, 4, 1'b0, dw, ow);
        @(negedge clk);
        va4 = a; vb4 = b; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n_vec++;
        if (rdy_s !== 1'b0 || cmp_s !== 1'b0) begin
            n_err++;
            $display("FAIL run4_busy: ready=%b complete=%b, required 0/0", rdy_s, cmp_s);
        end
        cyc = 0;
        while (cmp_s !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (cyc !== 3) begin
            n_err++;
            $display("FAIL run4_latency: got %0d cycles, required 3", cyc);
        end
        n_vec++;
        if (dot_s !== ds || ovf_s !== os || rdy_s !== 1'b1) begin
            n_err++;
            $display("FAIL run4_sat a=%h b=%h: dot=%h ovf=%b rdy=%b, required dot=%h ovf=%b rdy=1",
                     a, b, dot_s, ovf_s, rdy_s, ds, os);
        end
        n_vec++;
        if (dot_w !== dw || ovf_w !== ow || cmp_w !== 1'b1) begin
            n_err++;
            $display("FAIL run4_wrap a=%h b=%h: dot=%h ovf=%b cmp=%b, required dot=%h ovf=%b cmp=1",
                     a, b, dot_w, ovf_w, cmp_w, dw, ow);
        end
    endtask

    task automatic run5(input logic [79:0] a, input logic [79:0] b);
        logic [15:0] d;
        logic        o;
        int          cyc, lat52, lat55;
        model(a, b, 5, 1'b1, d, o);
        @(negedge clk);
        va5 = a; vb5 = b; start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        cyc = 0; lat52 = -1; lat55 = -1;
        while ((lat52 < 0 || lat55 < 0) && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cmp_52 === 1'b1 && lat52 < 0) lat52 = cyc;
            if (cmp_55 === 1'b1 && lat55 < 0) lat55 = cyc;
        end
        n_vec++;
        if (lat52 !== 4 || lat55 !== 2) begin
            n_err++;
            $display("FAIL run5_latency: L2=%0d L5=%0d, required 4 and 2", lat52, lat55);
        end
        n_vec++;
        if (dot_52 !== d || ovf_52 !== o || dot_55 !== d || ovf_55 !== o) begin
            n_err++;
            $display("FAIL run5_result: L2 dot=%h ovf=%b L5 dot=%h ovf=%b, required dot=%h ovf=%b",
                     dot_52, ovf_52, dot_55, ovf_55, d, o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start4 = 1'b0; start5 = 1'b0;
        va4 = '0; vb4 = '0; va5 = '0; vb5 = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (rdy_s !== 1'b1 || cmp_s !== 1'b0 || dot_s !== 16'h0 || ovf_s !== 1'b0 ||
            rdy_52 !== 1'b1 || cmp_55 !== 1'b0 || dot_w !== 16'h0) begin
            n_err++;
            $display("FAIL reset: rdy=%b cmp=%b dot=%h ovf=%b, required 1 0 0000 0",
                     rdy_s, cmp_s, dot_s, ovf_s);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run4({16'h0080, 16'hFF00, 16'h0200, 16'h0100}, {16'h0200, 16'h0100, 16'h0100, 16'h0100});
        n_vec++;
        if (dot_s !== 16'h0300 || ovf_s !== 1'b0) begin
            n_err++;
            $display("FAIL basic: dot=%h ovf=%b, required 0300 0", dot_s, ovf_s);
        end
        run4({4{16'h7FFF}}, {4{16'h7FFF}});
        n_vec++;
        if (dot_s !== 16'h7FFF || ovf_s !== 1'b1 || dot_w !== 16'hFC00 || ovf_w !== 1'b1) begin
            n_err++;
            $display("FAIL saturate: sat=%h/%b wrap=%h/%b, required 7fff/1 fc00/1",
                     dot_s, ovf_s, dot_w, ovf_w);
        end
        run4(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001);
        n_vec++;
        if (dot_s !== 16'hFFFF) begin
            n_err++;
            $display("FAIL floor_neg: dot=%h, required ffff", dot_s);
        end
        run4(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001);
        n_vec++;
        if (dot_s !== 16'h0000) begin
            n_err++;
            $display("FAIL floor_pos: dot=%h, required 0000", dot_s);
        end
        run4(64'h0000_0000_0000_FF80, 64'h0000_0000_0000_0080);
        n_vec++;
        if (dot_s !== 16'hFFC0) begin
            n_err++;
            $display("FAIL sign: dot=%h, required ffc0", dot_s);
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b;
        for (int t = 0; t < 24; t++) begin
            for (int e = 0; e < 4; e++) begin
                a[e*16 +: 16] = rand_elem();
                b[e*16 +: 16] = rand_elem();
            end
            run4(a, b);
        end
    endtask

    task automatic test_remainder();
        logic [79:0] a, b;
        run5({5{16'h0100}}, {5{16'h0100}});
        n_vec++;
        if (dot_52 !== 16'h0500 || dot_55 !== 16'h0500) begin
            n_err++;
            $display("FAIL remainder: L2 dot=%h L5 dot=%h, required 0500", dot_52, dot_55);
        end
        for (int t = 0; t < 8; t++) begin
            for (int e = 0; e < 5; e++) begin
                a[e*16 +: 16] = rand_elem();
                b[e*16 +: 16] = rand_elem();
            end
            run5(a, b);
        end
    endtask

    task automatic test_ignored_start();
        logic [63:0] a1, b1, a2, b2;
        logic [15:0] d1, d2;
        logic        o1, o2;
        int          cyc;
        a1 = {16'h0100, 16'h0300, 16'hFE00, 16'h0180};
        b1 = {16'h0200, 16'h0100, 16'h0100, 16'h0100};
        a2 = {16'h0040, 16'h0010, 16'h0500, 16'hF000};
        b2 = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
        model({16'h0, a1}, {16'h0, b1}, 4, 1'b1, d1, o1);
        model({16'h0, a2}, {16'h0, b2}, 4, 1'b1, d2, o2);
        @(negedge clk);
        va4 = a1; vb4 = b1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; va4 = a2; vb4 = b2;
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start4 = 1'b0;
        n_vec++;
        if (cmp_s !== 1'b1 || dot_s !== d1) begin
            n_err++;
            $display("FAIL ignored_start: cmp=%b dot=%h, required 1 %h", cmp_s, dot_s, d1);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (cmp_s !== 1'b1 || rdy_s !== 1'b1 || dot_s !== d1) begin
            n_err++;
            $display("FAIL done_hold: cmp=%b rdy=%b dot=%h, required 1 1 %h", cmp_s, rdy_s, dot_s, d1);
        end
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n_vec++;
        if (cmp_s !== 1'b0 || rdy_s !== 1'b0 || dot_s !== d1) begin
            n_err++;
            $display("FAIL restart_from_done: cmp=%b rdy=%b dot=%h, required 0 0 %h",
                     cmp_s, rdy_s, dot_s, d1);
        end
        cyc = 0;
        while (cmp_s !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (cyc !== 3 || dot_s !== d2 || ovf_s !== o2) begin
            n_err++;
            $display("FAIL second_op: lat=%0d dot=%h ovf=%b, required 3 %h %b", cyc, dot_s, ovf_s, d2, o2);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        va4 = {4{16'h0200}}; vb4 = {4{16'h0300}}; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (rdy_s !== 1'b1 || cmp_s !== 1'b0 || dot_s !== 16'h0 || ovf_s !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_run: rdy=%b cmp=%b dot=%h ovf=%b, required 1 0 0000 0",
                     rdy_s, cmp_s, dot_s, ovf_s);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (cmp_s !== 1'b0 || dot_s !== 16'h0) begin
            n_err++;
            $display("FAIL reset_abort: cmp=%b dot=%h, required 0 0000", cmp_s, dot_s);
        end
        run4({16'h0100, 16'hFF00, 16'h0080, 16'h0400}, {16'h0100, 16'h0100, 16'h0300, 16'h0100});
    endtask

    initial begin
        test_reset();
        test_directed();
        test_remainder();
        test_random();
        test_ignored_start();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
